watch_mode_sequencer: RTL and testbench
=======================================

# watch_mode_sequencer

Controller between the raw push-buttons and the seven watch function modules (date, clock, alarm, stopwatch, timer, d-day, ladder). Conditions the buttons into single-cycle events, owns the one-hot mode register and its rotation, and routes events to the active module only. Also arbitrates the modules' alarm requests and selects the registered display word for the active mode.

## Interface
- DEBOUNCE_CYCLES, 16'd50000, cycles a synchronized button level must stay stable before it is accepted (min 1)
- NUM_MODES, 7, number of function modules (mode register width)

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_n_i  in  6  raw buttons, active-low: [0]=up [1]=down [2]=left [3]=right [4]=enter [5]=esc
- norm_i  in  NUM_MODES  per-module idle flag; 1 = module in its normal (non-edit) state
- alarm_req_i  in  NUM_MODES  per-module alarm request level (only [2] alarm and [4] timer are wired; others tied 0)
- disp_i  in  48*NUM_MODES  six 8-bit digits per module; module k at [48k+47:48k]
- mode_o  out  NUM_MODES  one-hot active mode
- evt_o  out  6  single-cycle button events forwarded to the active module, same bit order as btn_n_i
- out_o  out  48  registered display word of the active mode
- o_m_o  out  8  {alarm_o, mode_o}
- alarm_o  out  1  alarm indicator

## Operation
- Conditioning: each button is inverted, passed through a 2-flop synchronizer, then debounced by its own counter. The accepted level updates after DEBOUNCE_CYCLES consecutive equal synchronized samples. Rising edge of the accepted level produces a raw one-cycle pulse p[5:0]. Release generates nothing.
- Mode rotation: when (mode_o & norm_i) != 0 and alarm_o == 0:
  - p[0] alone rotates left (mode[i+1] <= mode[i], mode[0] <= mode[NUM_MODES-1]).
  - p[1] alone rotates right.
  - Consumed up/down pulses are not forwarded.
- Up and down pulsed together: no rotation and neither is forwarded. Left/right/enter/esc in the same cycle are still forwarded.
- Forwarding: when the active module is not normal, all pulses pass to evt_o. In the normal state only p[5:2] pass.
- Alarm arbitration:
  - A rising edge on any alarm_req_i bit sets alarm_o.
  - If norm_i of the active mode is 1, mode_o jumps to the lowest-index newly-rising requester. Otherwise mode_o is unchanged.
  - While alarm_o=1, any pulse clears alarm_o (acknowledge). All pulses that cycle are swallowed: evt_o=0, no rotation.
  - alarm_o also clears when all alarm_req_i bits are 0.
  - A new rising edge in the same cycle as an acknowledge wins: alarm_o stays 1.
- Display: out_o <= disp_i slice selected by mode_o. o_m_o is the concatenation of registered signals.
- Mode integrity: if mode_o is ever not one-hot, the next cycle forces it to 1 (date).

## Timing
- Reset values: mode_o=7'b0000001, evt_o=0, out_o=0, o_m_o=8'h01, alarm_o=0. Synchronizers, debounce counters and accepted levels reset to 0 (released).
- Press latency: a raw edge is synchronized by cycle 2. The accepted level changes at cycle 2+DEBOUNCE_CYCLES. p and evt_o fire in the same cycle as the accepted-level change, registered.
- mode_o and alarm_o update 1 cycle after p. out_o follows mode_o 1 cycle later.
- evt_o is high for exactly 1 cycle per accepted press. A held button never repeats.
- A glitch shorter than DEBOUNCE_CYCLES resets that button's counter and produces no event.
- Alarm edge detect uses a registered copy of alarm_req_i. alarm_o rises 1 cycle after the request rises.
- Reset asserted mid-debounce or mid-alarm returns everything to reset values on the next clk-independent edge. A button held through reset release generates one press after the debounce period.

## Test plan
- DEBOUNCE_CYCLES=4, norm_i=7'h7F: press up for 10 cycles -> exactly one rotation, mode_o 01->02, evt_o stays 0. Repeat 7 times -> wraps back to 01.
- norm_i=0 on mode 02: press enter -> evt_o=6'b010000 for 1 cycle, mode_o unchanged. Press up -> evt_o=6'b000001 and no rotation.
- Press up+down together in the same cycle with norm=1 -> mode_o unchanged, evt_o=0. Add left in the same cycle -> evt_o=6'b000100.
- 3-cycle glitch on esc (DEBOUNCE_CYCLES=4) -> no event. 5-cycle press -> one event.
- mode_o=01, norm=1, alarm_req_i[4] rises -> alarm_o=1 and mode_o=7'b0010000 next cycle, o_m_o=8'h90. Press enter -> alarm_o=0, evt_o=0. Same-cycle new rise on [2] during the ack -> alarm_o stays 1.
- disp_i module 3 = 48'h0102030405_06, mode 3 active -> out_o equals it 1 cycle after mode_o changes. Assert rst mid-sequence -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/watch_mode_sequencer.sv
// Button conditioning, one-hot mode rotation, event routing, alarm arbitration
// and display selection for the seven watch function modules.
module watch_mode_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_MODES       = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5:0]                btn_n_i,
    input  logic [NUM_MODES-1:0]      norm_i,
    input  logic [NUM_MODES-1:0]      alarm_req_i,
    input  logic [48*NUM_MODES-1:0]   disp_i,
    output logic [NUM_MODES-1:0]      mode_o,
    output logic [5:0]                evt_o,
    output logic [47:0]               out_o,
    output logic [NUM_MODES:0]        o_m_o,
    output logic                      alarm_o
);

    localparam logic [NUM_MODES-1:0] MODE_DATE = {{(NUM_MODES-1){1'b0}}, 1'b1};
    localparam logic [15:0]          DB_LAST   = DEBOUNCE_CYCLES - 16'd1;

    logic [5:0]           sync1_reg;
    logic [5:0]           sync2_reg;
    logic [5:0]           level;
    logic [5:0]           rise;
    logic [5:0]           p_reg;
    logic [5:0]           evt_reg;
    logic [5:0]           evt_next;
    logic [NUM_MODES-1:0] mode_reg;
    logic [NUM_MODES-1:0] req_reg;
    logic [NUM_MODES-1:0] req_rise;
    logic [NUM_MODES-1:0] req_lowest;
    logic [47:0]          out_reg;
    logic [47:0]          disp_sel;
    logic                 alarm_reg;
    logic                 active_norm;
    logic                 mode_onehot;
    logic                 rot_left;
    logic                 rot_right;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= ~btn_n_i;
            sync2_reg <= sync1_reg;
        end
    end

    // One debouncer per button; any sample equal to the accepted level restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_btn
            logic [15:0] cnt_reg;
            logic        level_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    cnt_reg   <= '0;
                    level_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign level[gi] = level_reg;
            assign rise[gi]  = sync2_reg[gi] & ~level_reg & (cnt_reg == DB_LAST);
        end
    endgenerate

    assign active_norm = |(mode_reg & norm_i);
    assign mode_onehot = (mode_reg != '0) && ((mode_reg & (mode_reg - MODE_DATE)) == '0);
    assign req_rise    = alarm_req_i & ~req_reg;
    assign req_lowest  = req_rise & (~req_rise + MODE_DATE);

    // Up/down are consumed by rotation in the normal state; together they cancel.
    always_comb begin
        evt_next = '0;
        if (alarm_reg) begin
            evt_next = '0;
        end else if (!active_norm) begin
            evt_next = rise;
        end else begin
            evt_next = {rise[5:2], 2'b00};
        end
    end

    assign rot_left  = ~alarm_reg & active_norm & p_reg[0] & ~p_reg[1];
    assign rot_right = ~alarm_reg & active_norm & p_reg[1] & ~p_reg[0];

    always_comb begin
        disp_sel = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_reg[k]) begin
                disp_sel = disp_sel | disp_i[48*k +: 48];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg     <= '0;
            evt_reg   <= '0;
            req_reg   <= '0;
            out_reg   <= '0;
            mode_reg  <= MODE_DATE;
            alarm_reg <= 1'b0;
        end else begin
            p_reg   <= rise;
            evt_reg <= evt_next;
            req_reg <= alarm_req_i;
            out_reg <= disp_sel;

            if (!mode_onehot) begin
                mode_reg <= MODE_DATE;
            end else if (|req_rise) begin
                if (active_norm) begin
                    mode_reg <= req_lowest;
                end
            end else if (rot_left) begin
                mode_reg <= {mode_reg[NUM_MODES-2:0], mode_reg[NUM_MODES-1]};
            end else if (rot_right) begin
                mode_reg <= {mode_reg[0], mode_reg[NUM_MODES-1:1]};
            end

            // A fresh request outranks an acknowledge landing in the same cycle.
            if (|req_rise) begin
                alarm_reg <= 1'b1;
            end else if (alarm_reg && ((|p_reg) || (alarm_req_i == '0))) begin
                alarm_reg <= 1'b0;
            end
        end
    end

    assign mode_o  = mode_reg;
    assign evt_o   = evt_reg;
    assign out_o   = out_reg;
    assign alarm_o = alarm_reg;
    assign o_m_o   = {alarm_reg, mode_reg};

endmodule

// File: tb/tb_watch_mode_sequencer.sv
// Directed bench for watch_mode_sequencer with a 4-cycle debounce window.
module tb_watch_mode_sequencer;

    logic         clk;
    logic         rst;
    logic [5:0]   btn_n;
    logic [6:0]   norm;
    logic [6:0]   alarm_req;
    logic [335:0] disp;
    logic [6:0]   mode;
    logic [5:0]   evt;
    logic [47:0]  out;
    logic [7:0]   o_m;
    logic         alarm;

    int errors = 0;
    int checks = 0;

    watch_mode_sequencer #(
        .DEBOUNCE_CYCLES(16'd4),
        .NUM_MODES(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n_i(btn_n),
        .norm_i(norm),
        .alarm_req_i(alarm_req),
        .disp_i(disp),
        .mode_o(mode),
        .evt_o(evt),
        .out_o(out),
        .o_m_o(o_m),
        .alarm_o(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_collect(input logic [5:0] mask, input int hold, input int settle,
                                 output logic [5:0] evt_acc, output int evt_cycles);
        evt_acc    = '0;
        evt_cycles = 0;
        btn_n      = ~mask;
        for (int i = 0; i < hold + settle; i++) begin
            if (i == hold) btn_n = 6'h3F;
            tick();
            if (evt != 6'b0) begin
                evt_cycles++;
                evt_acc = evt_acc | evt;
            end
        end
        $display("press mask=%b hold=%0d evt=%b evt_cycles=%0d mode=%b alarm=%b",
                 mask, hold, evt_acc, evt_cycles, mode, alarm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_n = 6'h3F;
        norm = 7'h7F;
        alarm_req = '0;
        for (int k = 0; k < 7; k++) disp[48*k +: 48] = {6{8'(k + 1)}};
        disp[48*3 +: 48] = 48'h010203040506;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (mode !== 7'b0000001) begin errors++; $display("FAIL reset_mode got=%b exp=%b", mode, 7'b0000001); end
        checks++; if (evt !== 6'b0) begin errors++; $display("FAIL reset_evt got=%b exp=%b", evt, 6'b0); end
        checks++; if (out !== 48'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", out, 48'h0); end
        checks++; if (o_m !== 8'h01) begin errors++; $display("FAIL reset_om got=%h exp=%h", o_m, 8'h01); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=%b", alarm, 1'b0); end
        $display("reset released mode=%b o_m=%h", mode, o_m);
    endtask

    task automatic test_rotation();
        logic [6:0] exp_mode;
        logic [5:0] acc;
        int         n;
        exp_mode = 7'b0000001;
        norm = 7'h7F;
        for (int r = 0; r < 7; r++) begin
            press_collect(6'b000001, 10, 8, acc, n);
            exp_mode = {exp_mode[5:0], exp_mode[6]};
            checks++; if (n !== 0) begin errors++; $display("FAIL rot_evt step=%0d got=%0d cycles exp=0", r, n); end
            checks++; if (mode !== exp_mode) begin errors++; $display("FAIL rot_mode step=%0d got=%b exp=%b", r, mode, exp_mode); end
        end
        checks++; if (mode !== 7'b0000001) begin errors++; $display("FAIL rot_wrap got=%b exp=%b", mode, 7'b0000001); end
    endtask

    task automatic test_forwarding();
        logic [5:0] acc;
        int         n;
        norm = 7'h7F;
        press_collect(6'b000001, 10, 8, acc, n);
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL fwd_setup got=%b exp=%b", mode, 7'b0000010); end
        norm = 7'h00;
        press_collect(6'b010000, 10, 8, acc, n);
        checks++; if (acc !== 6'b010000) begin errors++; $display("FAIL fwd_enter_evt got=%b exp=%b", acc, 6'b010000); end
        checks++; if (n !== 1) begin errors++; $display("FAIL fwd_enter_cycles got=%0d exp=1", n); end
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL fwd_enter_mode got=%b exp=%b", mode, 7'b0000010); end
        press_collect(6'b000001, 10, 8, acc, n);
        checks++; if (acc !== 6'b000001) begin errors++; $display("FAIL fwd_up_evt got=%b exp=%b", acc, 6'b000001); end
        checks++; if (n !== 1) begin errors++; $display("FAIL fwd_up_cycles got=%0d exp=1", n); end
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL fwd_up_mode got=%b exp=%b", mode, 7'b0000010); end
        norm = 7'h7F;
    endtask

    task automatic test_up_down();
        logic [5:0] acc;
        int         n;
        press_collect(6'b000011, 10, 8, acc, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL ud_evt got=%0d cycles exp=0", n); end
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL ud_mode got=%b exp=%b", mode, 7'b0000010); end
        press_collect(6'b000111, 10, 8, acc, n);
        checks++; if (acc !== 6'b000100) begin errors++; $display("FAIL udl_evt got=%b exp=%b", acc, 6'b000100); end
        checks++; if (n !== 1) begin errors++; $display("FAIL udl_cycles got=%0d exp=1", n); end
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL udl_mode got=%b exp=%b", mode, 7'b0000010); end
    endtask

    task automatic test_glitch();
        logic [5:0] acc;
        int         n;
        press_collect(6'b100000, 3, 8, acc, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL glitch_evt got=%0d cycles exp=0", n); end
        press_collect(6'b100000, 5, 8, acc, n);
        checks++; if (acc !== 6'b100000) begin errors++; $display("FAIL esc_evt got=%b exp=%b", acc, 6'b100000); end
        checks++; if (n !== 1) begin errors++; $display("FAIL esc_cycles got=%0d exp=1", n); end
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL esc_mode got=%b exp=%b", mode, 7'b0000010); end
    endtask

    task automatic test_alarm();
        logic [5:0] acc;
        int         n;
        press_collect(6'b000010, 10, 8, acc, n);
        checks++; if (mode !== 7'b0000001) begin errors++; $display("FAIL alm_setup got=%b exp=%b", mode, 7'b0000001); end
        alarm_req = 7'b0010000;
        tick();
        $display("alarm request %b mode=%b alarm=%b o_m=%h", alarm_req, mode, alarm, o_m);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alm_rise got=%b exp=1", alarm); end
        checks++; if (mode !== 7'b0010000) begin errors++; $display("FAIL alm_jump got=%b exp=%b", mode, 7'b0010000); end
        checks++; if (o_m !== 8'h90) begin errors++; $display("FAIL alm_om got=%h exp=%h", o_m, 8'h90); end
        press_collect(6'b010000, 10, 8, acc, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL ack_evt got=%0d cycles exp=0", n); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL ack_alarm got=%b exp=0", alarm); end
        checks++; if (mode !== 7'b0010000) begin errors++; $display("FAIL ack_mode got=%b exp=%b", mode, 7'b0010000); end

        alarm_req = 7'b0000000;
        tick();
        alarm_req = 7'b0010000;
        tick();
        n = 0;
        btn_n = ~6'b010000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt != 6'b0) n++;
        end
        alarm_req = 7'b0010100;
        tick();
        if (evt != 6'b0) n++;
        $display("ack with new request %b mode=%b alarm=%b", alarm_req, mode, alarm);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL ack_rise_alarm got=%b exp=1", alarm); end
        checks++; if (mode !== 7'b0000100) begin errors++; $display("FAIL ack_rise_mode got=%b exp=%b", mode, 7'b0000100); end
        for (int i = 0; i < 11; i++) begin
            if (i == 3) btn_n = 6'h3F;
            tick();
            if (evt != 6'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL ack_rise_evt got=%0d cycles exp=0", n); end
        alarm_req = 7'b0000000;
        tick();
        $display("requests dropped alarm=%b", alarm);
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL req_clear got=%b exp=0", alarm); end
    endtask

    task automatic test_display();
        btn_n = ~6'b000001;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (mode !== 7'b0001000) begin errors++; $display("FAIL disp_mode got=%b exp=%b", mode, 7'b0001000); end
        checks++; if (out !== 48'h030303030303) begin errors++; $display("FAIL disp_prev got=%h exp=%h", out, 48'h030303030303); end
        tick();
        $display("display mode=%b out=%h", mode, out);
        checks++; if (out !== 48'h010203040506) begin errors++; $display("FAIL disp_out got=%h exp=%h", out, 48'h010203040506); end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) btn_n = 6'h3F;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        alarm_req = 7'b0010000;
        tick();
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL mid_alarm_setup got=%b exp=1", alarm); end
        btn_n = ~6'b000001;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        alarm_req = 7'b0000000;
        #1;
        $display("reset asserted mode=%b evt=%b out=%h o_m=%h alarm=%b", mode, evt, out, o_m, alarm);
        checks++; if (mode !== 7'b0000001) begin errors++; $display("FAIL mid_mode got=%b exp=%b", mode, 7'b0000001); end
        checks++; if (evt !== 6'b0) begin errors++; $display("FAIL mid_evt got=%b exp=0", evt); end
        checks++; if (out !== 48'h0) begin errors++; $display("FAIL mid_out got=%h exp=0", out); end
        checks++; if (o_m !== 8'h01) begin errors++; $display("FAIL mid_om got=%h exp=01", o_m); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL mid_alarm got=%b exp=0", alarm); end
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt != 6'b0) n++;
        end
        btn_n = 6'h3F;
        for (int i = 0; i < 8; i++) tick();
        $display("held through reset mode=%b evt_cycles=%0d", mode, n);
        checks++; if (mode !== 7'b0000010) begin errors++; $display("FAIL held_mode got=%b exp=%b", mode, 7'b0000010); end
        checks++; if (n !== 0) begin errors++; $display("FAIL held_evt got=%0d cycles exp=0", n); end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_forwarding();
        test_up_down();
        test_glitch();
        test_alarm();
        test_display();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
